// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the 32-bit LFSR test-pattern link. Both the
//   generator and the checker import this package so the polynomial lives in
//   exactly one place.
//
//   Contents:
//     LFSR_W            word width of the pattern (32)
//     TAP_A..TAP_E      feedback tap positions (7, 16, 19, 25, 29)
//     lfsr_state_e      checker synchronisation states (HUNT, SYNC, LOCKED)
//     lfsr_next()       one step of the generator: shift left, feedback in bit 0
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 32;

    localparam int TAP_A = 7;
    localparam int TAP_B = 16;
    localparam int TAP_C = 19;
    localparam int TAP_D = 25;
    localparam int TAP_E = 29;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D] ^ s[TAP_E];
        return {s[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// ----------------------------------------------------------------------------
// lfsr_step
//   Purely combinational next-state of the 32-bit pattern LFSR.
//
//   Ports:
//     state_i  [LFSR_W-1:0]  current generator state word
//     next_o   [LFSR_W-1:0]  state word the generator emits next
// ----------------------------------------------------------------------------
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] next_o
);

    assign next_o = lfsr_next(state_i);

endmodule

// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr_checker
//   Receive-side checker for the 32-bit LFSR test pattern. It seeds itself
//   from the incoming words, confirms LOCK_COUNT consecutive correct
//   predictions, then flywheels its own prediction and counts mismatching
//   words while locked. LOSS_COUNT consecutive misses drop lock.
//
//   Optional feature (macro LFSR_CHECKER_BITCNT_EN):
//     adds parameter BIT_CNT_W and output bit_err_count, a saturating sum of
//     the number of wrong bits in every mismatching word while locked.
//
//   Ports:
//     clk            clock, all state changes on rising edge
//     rst            asynchronous reset, active low
//     in_valid       in_data holds a generator word this cycle
//     in_data[31:0]  received generator state word
//     clr_cnt        synchronous clear of the error counter(s)
//     locked         checker is in LOCKED
//     err_pulse      one cycle high after a mismatching word while locked
//     err_count      saturating count of mismatching words while locked
//     bit_err_count  (optional) saturating count of wrong bits while locked
// ----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int ERR_CNT_W  = 16
`ifdef LFSR_CHECKER_BITCNT_EN
    ,
    parameter int BIT_CNT_W  = 24
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [LFSR_W-1:0]    in_data,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef LFSR_CHECKER_BITCNT_EN
    ,
    output logic [BIT_CNT_W-1:0] bit_err_count
`endif
);

    // The run counter holds either consecutive matches (SYNC) or consecutive
    // misses (LOCKED); it never exceeds the larger threshold minus one.
    localparam int RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
    localparam int RUN_W   = (RUN_MAX < 1) ? 1 : $clog2(RUN_MAX + 1);

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + ERR_CNT_W'(1);
    endfunction

`ifdef LFSR_CHECKER_BITCNT_EN
    function automatic logic [5:0] popcount32(input logic [LFSR_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [BIT_CNT_W-1:0] sat_add_bits(input logic [BIT_CNT_W-1:0] c,
                                                          input logic [5:0]           n);
        logic [BIT_CNT_W:0] sum;
        sum = {1'b0, c} + (BIT_CNT_W+1)'(n);
        if (sum[BIT_CNT_W]) begin
            return '1;
        end
        return sum[BIT_CNT_W-1:0];
    endfunction
`endif

    // ------------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------------
    lfsr_state_e          state_q, state_d;
    logic [LFSR_W-1:0]    exp_q, exp_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 locked_q, locked_d;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`endif

    // ------------------------------------------------------------------------
    // Next-state predictors: one seeds from the received word, the other
    // flywheels the stored prediction once locked.
    // ------------------------------------------------------------------------
    logic [LFSR_W-1:0] nxt_in;
    logic [LFSR_W-1:0] nxt_exp;

    lfsr_step u_step_in (
        .state_i (in_data),
        .next_o  (nxt_in)
    );

    lfsr_step u_step_exp (
        .state_i (exp_q),
        .next_o  (nxt_exp)
    );

    // An all-zero word is the LFSR lock-up state: never a seed, never a match.
    logic              word_nz;
    logic              word_match;
    logic [RUN_W-1:0]  run_inc;
    logic              count_err;

    assign word_nz    = |in_data;
    assign word_match = word_nz && (in_data == exp_q);
    assign run_inc    = run_q + RUN_W'(1);

    // ------------------------------------------------------------------------
    // Synchronisation state machine and error accounting
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (word_nz) begin
                        exp_d   = nxt_in;
                        run_d   = '0;
                        state_d = SYNC;
                    end
                end

                SYNC: begin
                    if (word_match) begin
                        exp_d = nxt_in;
                        if (run_inc == RUN_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        // Broken prediction while syncing: restart from this
                        // word if usable, otherwise go back to hunting.
                        run_d = '0;
                        if (word_nz) begin
                            exp_d = nxt_in;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end

                LOCKED: begin
                    // Flywheel: the prediction never follows the input once
                    // locked, so a corrupted word cannot poison the sequence.
                    exp_d = nxt_exp;
                    if (word_match) begin
                        run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        if (run_inc == RUN_W'(LOSS_COUNT)) begin
                            state_d = HUNT;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
            endcase
        end

        // Clear wins over increment; a clear together with an error leaves 1.
        if (clr_cnt) begin
            err_cnt_d = count_err ? ERR_CNT_W'(1) : '0;
        end else if (count_err) begin
            err_cnt_d = sat_inc_err(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end

        locked_d = (state_d == LOCKED);
    end

`ifdef LFSR_CHECKER_BITCNT_EN
    logic [5:0] bad_bits;
    assign bad_bits = popcount32(in_data ^ exp_q);

    always_comb begin
        if (clr_cnt) begin
            bit_cnt_d = count_err ? sat_add_bits('0, bad_bits) : '0;
        end else if (count_err) begin
            bit_cnt_d = sat_add_bits(bit_cnt_q, bad_bits);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            run_q       <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
`ifdef LFSR_CHECKER_BITCNT_EN
            bit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            run_q       <= run_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
`ifdef LFSR_CHECKER_BITCNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
`ifdef LFSR_CHECKER_BITCNT_EN
    assign bit_err_count = bit_cnt_q;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

    localparam int LOCK_N  = 4;
    localparam int LOSS_N  = 3;
    localparam int ERR_W   = 16;
    localparam int SMALL_W = 4;
    localparam int BITS_W  = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        clr_cnt = 1'b0;

    logic             locked, err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             locked_s, err_pulse_s;
    logic [SMALL_W-1:0] err_count_s;
`ifdef LFSR_CHECKER_BITCNT_EN
    logic [BITS_W-1:0] bit_err_count, bit_err_count_s;
`endif

    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_CNT_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
`ifdef LFSR_CHECKER_BITCNT_EN
        , .bit_err_count(bit_err_count)
`endif
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    lfsr_checker #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_CNT_W(SMALL_W)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
`ifdef LFSR_CHECKER_BITCNT_EN
        , .bit_err_count(bit_err_count_s)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural reference: mode 0=hunting, 1=syncing, 2=locked.
    int          m_mode;
    logic [31:0] m_exp;
    int          m_run;
    longint      m_cnt;
    bit          m_pulse;
    longint      m_bits;

    logic [31:0] g_state;

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic fb;
        fb = s[7] ^ s[16] ^ s[19] ^ s[25] ^ s[29];
        return (s << 1) | {31'd0, fb};
    endfunction

    function automatic longint clampc(input longint c, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = '0; m_run = 0; m_cnt = 0; m_pulse = 0; m_bits = 0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        w = in_data;
        m_pulse = 0;
        if (clr_cnt) begin
            m_cnt  = 0;
            m_bits = 0;
        end
        if (in_valid) begin
            case (m_mode)
                0: if (w != 0) begin
                       m_exp = ref_next(w); m_run = 0; m_mode = 1;
                   end
                1: if (w == m_exp && w != 0) begin
                       m_run++;
                       m_exp = ref_next(w);
                       if (m_run == LOCK_N) begin m_mode = 2; m_run = 0; end
                   end else begin
                       m_run = 0;
                       if (w != 0) m_exp = ref_next(w);
                       else        m_mode = 0;
                   end
                default: begin
                    if (w == m_exp && w != 0) begin
                        m_run = 0;
                    end else begin
                        m_pulse = 1;
                        m_cnt++;
                        m_bits += $countones(w ^ m_exp);
                        m_run++;
                        if (m_run == LOSS_N) begin m_mode = 0; m_run = 0; end
                    end
                    m_exp = ref_next(m_exp);
                end
            endcase
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit c);
        in_valid = v;
        in_data  = d;
        clr_cnt  = c;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic gen(output logic [31:0] w);
        w = g_state;
        g_state = ref_next(g_state);
    endtask

    task automatic do_reset();
        in_valid = 0; in_data = '0; clr_cnt = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        #3;
        rst = 1;
        drive(0, '0, 0);
    endtask

    task automatic lock_stream();
        logic [31:0] w;
        g_state = $urandom | 32'h1;
        for (int i = 0; i < LOCK_N + 1; i++) begin
            gen(w);
            drive(1, w, 0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%0b want=0", err_pulse); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_count got=%0h want=0", err_count); end
        checks++; if (err_count_s !== '0) begin errors++; $display("FAIL reset_count_s got=%0h want=0", err_count_s); end
    endtask

    task automatic test_lock_pattern();
        logic [31:0] words [5];
        words = '{32'h0000_0080, 32'h0000_0101, 32'h0000_0202, 32'h0000_0404, 32'h0000_0808};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, words[i], 0);
            checks++;
            if (locked !== (i == 4)) begin
                errors++; $display("FAIL lock_word%0d locked got=%0b want=%0b", i, locked, (i == 4));
            end
        end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL lock_count got=%0h want=0", err_count); end
        g_state = ref_next(32'h0000_0808);
    endtask

    task automatic test_single_err();
        logic [31:0] w;
        gen(w);
        drive(1, w ^ 32'h1, 0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got=%0b want=1", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0h want=1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got=%0b want=1", locked); end
        gen(w);
        drive(1, w, 0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL single_next_pulse got=%0b want=0", err_pulse); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_next_count got=%0h want=1", err_count); end
        drive(0, '0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_gap_locked got=%0b want=1", locked); end
    endtask

    task automatic test_loss_relock();
        logic [31:0] w;
        drive(0, '0, 1);
        checks++; if (err_count !== '0) begin errors++; $display("FAIL clr_count got=%0h want=0", err_count); end
        for (int i = 0; i < LOSS_N; i++) begin
            gen(w);
            drive(1, ~w, 0);
            checks++;
            if (locked !== (i < LOSS_N - 1)) begin
                errors++; $display("FAIL loss_locked%0d got=%0b want=%0b", i, locked, (i < LOSS_N - 1));
            end
            checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse%0d got=%0b want=1", i, err_pulse); end
        end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL loss_count got=%0h want=3", err_count); end
        for (int i = 0; i < LOCK_N + 1; i++) begin
            if (i == 2) drive(0, '0, 0);
            gen(w);
            drive(1, w, 0);
            checks++;
            if (locked !== (i == LOCK_N)) begin
                errors++; $display("FAIL relock_word%0d got=%0b want=%0b", i, locked, (i == LOCK_N));
            end
        end
        checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL relock_count got=%0h want=3", err_count); end
    endtask

    task automatic test_zero_hunt();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, '0, 0);
            checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_locked%0d got=%0b want=0", i, locked); end
            checks++; if (err_count !== '0) begin errors++; $display("FAIL zero_count%0d got=%0h want=0", i, err_count); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        do_reset();
        lock_stream();
        for (int i = 0; i < 10; i++) begin
            gen(w); drive(1, w ^ 32'h8000_0001, 0);
            gen(w); drive(1, w ^ 32'h0001_0000, 0);
            gen(w); drive(1, w, 0);
        end
        checks++; if (err_count_s !== 4'hF) begin errors++; $display("FAIL sat_small got=%0h want=f", err_count_s); end
        checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_main got=%0d want=20", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got=%0b want=1", locked); end
        gen(w); drive(1, w ^ 32'h10, 0);
        checks++; if (err_count_s !== 4'hF) begin errors++; $display("FAIL sat_hold got=%0h want=f", err_count_s); end
        checks++; if (err_pulse_s !== 1'b1) begin errors++; $display("FAIL sat_pulse got=%0b want=1", err_pulse_s); end
        gen(w); drive(1, w ^ 32'h10, 1);
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL clr_err_main got=%0d want=1", err_count); end
        checks++; if (err_count_s !== 4'd1) begin errors++; $display("FAIL clr_err_small got=%0d want=1", err_count_s); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_err_locked got=%0b want=1", locked); end
    endtask

    task automatic test_async_reset();
        logic [31:0] w;
        do_reset();
        lock_stream();
        gen(w);
        drive(1, w ^ 32'h4, 0);
        #2;
        rst = 0;
        model_reset();
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got=%0b want=0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL arst_pulse got=%0b want=0", err_pulse); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL arst_count got=%0h want=0", err_count); end
        @(negedge clk);
        #3;
        rst = 1;
        in_valid = 0;
        drive(0, '0, 0);
        gen(w);
        drive(1, w, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_rehunt got=%0b want=0", locked); end
    endtask

`ifdef LFSR_CHECKER_BITCNT_EN
    task automatic test_bitcnt();
        logic [31:0] w;
        do_reset();
        lock_stream();
        gen(w);
        drive(1, w ^ 32'h0000_0F00, 0);
        checks++; if (bit_err_count !== 24'd4) begin errors++; $display("FAIL bitcnt got=%0d want=4", bit_err_count); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] w;
        bit v, c;
        int r;
        do_reset();
        g_state = $urandom | 32'h1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) < 3);
            w = '0;
            if (v) begin
                r = $urandom_range(0, 99);
                if (r < 2) g_state = $urandom | 32'h1;
                gen(w);
                if (r >= 2 && r < 12)       w = w ^ (32'h1 << $urandom_range(0, 31));
                else if (r >= 12 && r < 15) w = '0;
            end
            drive(v, w, c);
            checks++;
            if (locked !== (m_mode == 2) || err_pulse !== m_pulse ||
                err_count !== ERR_W'(clampc(m_cnt, ERR_W)) ||
                err_count_s !== SMALL_W'(clampc(m_cnt, SMALL_W))) begin
                errors++;
                $display("FAIL random cyc=%0d got lk=%0b p=%0b c=%0d cs=%0d want lk=%0b p=%0b c=%0d cs=%0d",
                         cyc, locked, err_pulse, err_count, err_count_s, (m_mode == 2), m_pulse,
                         clampc(m_cnt, ERR_W), clampc(m_cnt, SMALL_W));
            end
`ifdef LFSR_CHECKER_BITCNT_EN
            checks++;
            if (bit_err_count !== BITS_W'(clampc(m_bits, BITS_W))) begin
                errors++;
                $display("FAIL random_bits cyc=%0d got=%0d want=%0d", cyc, bit_err_count, clampc(m_bits, BITS_W));
            end
`endif
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        g_state = 32'h1;
        test_reset();
        test_lock_pattern();
        test_single_err();
        test_loss_relock();
        test_zero_hunt();
        test_saturation();
        test_async_reset();
`ifdef LFSR_CHECKER_BITCNT_EN
        test_bitcnt();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
